// File: rtl/vga_tick_decoder.sv
// vga_tick_decoder: converts each toggle of the divided slow clock into a one-cycle tick in the
// CLOCK_50 domain, plus step strobe, tick counter and stall watchdog. Option: TICK_DECODER_MISS_COUNT_EN.
module vga_tick_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TICKS_PER_STEP = 4,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        slow_clk_in,
    input  logic        enable,
    output logic        tick,
    output logic        step,
    output logic [31:0] tick_count,
    output logic        stalled,
    output logic [1:0]  state
`ifdef TICK_DECODER_MISS_COUNT_EN
    ,
    output logic [15:0] miss_count
`endif
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam int SC_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int WU_W = $clog2(SYNC_STAGES + 2);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(TICKS_PER_STEP - 1);
    localparam logic [WU_W-1:0] WU_INIT = WU_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUN     = 2'd2,
        STALLED = 2'd3
    } state_e;

    state_e                 cur_state;
    state_e                 nxt_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   edge_det;
    logic                   tick_nxt;
    logic                   timeout;
    logic [WU_W-1:0]        warmup;
    logic [WD_W-1:0]        wd;
    logic [SC_W-1:0]        step_cnt;

    assign edge_det = sync_q[SYNC_STAGES-1] ^ prev;
    assign timeout  = (wd == WD_LAST);
    // Warmup hides the artificial edge seen when the chain leaves reset while the input is high.
    assign tick_nxt = edge_det & enable & (cur_state != IDLE) & (warmup == '0);

    assign state   = cur_state;
    assign stalled = (cur_state == STALLED);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev   <= 1'b0;
            warmup <= WU_INIT;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
            prev   <= sync_q[SYNC_STAGES-1];
            if (warmup != '0)
                warmup <= warmup - WU_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            cur_state <= IDLE;
        else
            cur_state <= nxt_state;
    end

    // Dropping enable wins over everything, including an edge seen in the same cycle.
    always_comb begin
        nxt_state = cur_state;
        if (!enable) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:       nxt_state = ARMED;
                ARMED, RUN: begin
                    if (tick_nxt)
                        nxt_state = RUN;
                    else if (timeout)
                        nxt_state = STALLED;
                end
                STALLED:    if (tick_nxt) nxt_state = RUN;
                default:    nxt_state = IDLE;
            endcase
        end
    end

    // Watchdog saturates at the timeout value so a stall is reported once, not re-triggered.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            wd <= '0;
        else if (cur_state == IDLE || tick_nxt)
            wd <= '0;
        else if (!timeout)
            wd <= wd + WD_W'(1);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick       <= 1'b0;
            step       <= 1'b0;
            step_cnt   <= '0;
            tick_count <= '0;
        end else begin
            tick       <= tick_nxt;
            step       <= tick_nxt & (step_cnt == SC_LAST);
            tick_count <= tick_count + 32'(tick_nxt);
            if (nxt_state == IDLE)
                step_cnt <= '0;
            else if (tick_nxt)
                step_cnt <= (step_cnt == SC_LAST) ? '0 : step_cnt + SC_W'(1);
        end
    end

`ifdef TICK_DECODER_MISS_COUNT_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            miss_count <= '0;
        else if ((cur_state == ARMED || cur_state == RUN) && nxt_state == STALLED
                 && miss_count != 16'hFFFF)
            miss_count <= miss_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_tick_decoder.sv
// Scoreboard bench for vga_tick_decoder: per-edge expectations derived from toggle/enable history.
module tb_vga_tick_decoder;

    localparam int S    = 2;
    localparam int TPS  = 4;
    localparam int T    = 100;
    localparam int MAXE = 8192;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        slow_clk_in;
    logic        enable;
    logic        tick, step, stalled;
    logic [31:0] tick_count;
    logic [1:0]  state;
`ifdef TICK_DECODER_MISS_COUNT_EN
    logic [15:0] miss_count;
`endif

    vga_tick_decoder #(
        .SYNC_STAGES(S), .TICKS_PER_STEP(TPS), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .slow_clk_in(slow_clk_in), .enable(enable),
        .tick(tick), .step(step), .tick_count(tick_count), .stalled(stalled), .state(state)
`ifdef TICK_DECODER_MISS_COUNT_EN
        , .miss_count(miss_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic        tick;
        logic        step;
        logic [31:0] cnt;
        logic [1:0]  st;
        logic        stl;
        logic [15:0] miss;
    } rec_t;

    rec_t q[$];
    int   eq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference history, indexed by clock edge number
    bit          en_h[MAXE];
    bit          tg_h[MAXE];
    int          rel = 1;
    bit          idle = 1;
    int          anchor = 0;
    bit          ran = 0;
    int          tsi = 0;
    logic [31:0] mcnt = 0;
    int          mmiss = 0;
    bit          prev_rst = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic rec_t sample();
        rec_t a;
        a.tick = tick; a.step = step; a.cnt = tick_count; a.st = state; a.stl = stalled;
`ifdef TICK_DECODER_MISS_COUNT_EN
        a.miss = miss_count;
`else
        a.miss = '0;
`endif
        return a;
    endfunction

    // Drive inputs for the next edge and queue what the outputs must be after that edge.
    task automatic drive(input bit en, input bit tg, input bit rst);
        int   e;
        bit   tk;
        rec_t x;
        rec_t a;
        e = cyc + 1;
        enable = en;
        if (tg) slow_clk_in = ~slow_clk_in;
        reset = rst;
        if (rst && !prev_rst) begin
            #1;
            a = sample();
            checks++;
            if (a !== '0) begin
                errors++;
                $display("FAIL async_reset: got %h required 0", a);
            end
        end
        en_h[e] = en;
        tg_h[e] = tg;
        x = '0;
        if (rst) begin
            rel = e + 1; idle = 1; ran = 0; tsi = 0; mcnt = 0; mmiss = 0;
        end else begin
            tk = (e - S >= rel + 1) && en && en_h[e-1] && tg_h[e-S];
            if (!en) begin
                idle = 1; tsi = 0; x.st = 2'd0;
            end else begin
                if (idle) begin idle = 0; anchor = e; ran = 0; end
                if (tk) begin
                    anchor = e; ran = 1; mcnt = mcnt + 1; tsi++;
                    x.tick = 1'b1;
                    x.step = (tsi % TPS == 0);
                end
                if (e - anchor >= T) begin
                    x.st = 2'd3;
                    if (e - anchor == T && mmiss < 16'hFFFF) mmiss++;
                end else begin
                    x.st = ran ? 2'd2 : 2'd1;
                end
            end
            x.cnt  = mcnt;
            x.stl  = (x.st == 2'd3);
            x.miss = 16'(mmiss);
        end
`ifndef TICK_DECODER_MISS_COUNT_EN
        x.miss = '0;
`endif
        q.push_back(x);
        eq.push_back(e);
        prev_rst = rst;
        @(negedge CLOCK_50);
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge
    initial begin
        rec_t x, a;
        int   e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                e = eq.pop_front();
                a = sample();
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL edge_%0d: got tick=%b step=%b cnt=%0d state=%0d stalled=%b miss=%0d, required tick=%b step=%b cnt=%0d state=%0d stalled=%b miss=%0d",
                             e, a.tick, a.step, a.cnt, a.st, a.stl, a.miss,
                             x.tick, x.step, x.cnt, x.st, x.stl, x.miss);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL time_limit: got running required finished");
        $fatal(1, "time limit");
    end

    initial begin
        bit en_r;
        bit tg, rs;
        int r, quiet;
        slow_clk_in = 1'b0;
        enable      = 1'b0;
        repeat (3) drive(0, 0, 1);
        // Eight toggles 20 cycles apart, steps on ticks 4 and 8
        repeat (3) drive(1, 0, 0);
        repeat (8) begin
            drive(1, 1, 0);
            repeat (19) drive(1, 0, 0);
        end
        // Silence long enough to stall, then recover
        repeat (150) drive(1, 0, 0);
        drive(1, 1, 0);
        repeat (10) drive(1, 0, 0);
        // Toggling while disabled, then re-enable with input high
        repeat (5) begin
            drive(0, 1, 0);
            repeat (7) drive(0, 0, 0);
        end
        if (!slow_clk_in) drive(0, 1, 0);
        repeat (5) drive(0, 0, 0);
        repeat (20) drive(1, 0, 0);
        drive(1, 1, 0);
        repeat (10) drive(1, 0, 0);
        // Enable falls exactly when the edge reaches the detector
        drive(1, 1, 0);
        repeat (S - 1) drive(1, 0, 0);
        repeat (6) drive(0, 0, 0);
        // Reset mid-run with the input held high
        repeat (3) drive(1, 0, 0);
        drive(1, 1, 0);
        repeat (6) drive(1, 0, 0);
        if (!slow_clk_in) begin
            drive(1, 1, 0);
            repeat (6) drive(1, 0, 0);
        end
        repeat (3) drive(1, 0, 1);
        repeat (10) drive(1, 0, 0);
        drive(1, 1, 0);
        repeat (10) drive(1, 0, 0);
        // Randomized traffic: toggles, enable flips, quiet spans, short resets
        en_r  = 1'b1;
        quiet = 0;
        repeat (2500) begin
            r  = $urandom_range(0, 999);
            tg = 1'b0;
            rs = 1'b0;
            if (quiet > 0) quiet--;
            else if (r < 10) quiet = $urandom_range(100, 170);
            else if (r < 40) en_r = ~en_r;
            else if (r < 43) rs = 1'b1;
            else if (r < 140) tg = 1'b1;
            drive(en_r, tg, rs);
        end
        @(posedge CLOCK_50);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
